// File: rtl/serial_resp_frame_encoder.sv
// serial_resp_frame_encoder
//   Response-side framer for the serial command link. Wraps a response payload as
//   SOF SOF SPACE <len> <payload...> [CSUM] EOF EOF and hands the bytes one at a
//   time to the UART transmitter through a single registered output slot.
//   Optional feature macro: SERIAL_RESP_CHECKSUM_EN inserts an XOR checksum byte
//   (len ^ payload bytes) between the payload and the first EOF byte.
module serial_resp_frame_encoder #(
  parameter int         MAX_PAYLOAD_LEN = 16,
  parameter logic [7:0] SOF_BYTE        = 8'hFF,
  parameter logic [7:0] SPACE_BYTE      = 8'h00,
  parameter logic [7:0] EOF_BYTE        = 8'hEE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       resp_valid,
  output logic       resp_ready,
  input  logic [7:0] resp_len,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       err_len
);

  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD_LEN);

  // Each state names the byte that is loaded into the slot next. The first SOF
  // is loaded on request acceptance, so the walk starts at the second SOF.
  // ST_DRAIN holds the final EOF in the slot until the transmitter takes it.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SOF2,
    ST_SPACE,
    ST_LEN,
    ST_PAYLOAD,
`ifdef SERIAL_RESP_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_EOF1,
    ST_EOF2,
    ST_DRAIN
  } state_t;

`ifdef SERIAL_RESP_CHECKSUM_EN
  localparam state_t ST_AFTER_PL = ST_CSUM;
`else
  localparam state_t ST_AFTER_PL = ST_EOF1;
`endif

  state_t     r_state;
  logic [7:0] r_len;
  logic [7:0] r_cnt;
  logic [7:0] r_tx_data;
  logic       r_tx_valid;
  logic       r_busy;
  logic       r_err_len;
  logic       r_resp_ready;
`ifdef SERIAL_RESP_CHECKSUM_EN
  logic [7:0] r_csum;
`endif

  logic w_slot_free;
  logic w_pl_take;

  // Slot can be refilled when empty or when its byte is consumed this cycle.
  // NOTE: continuous assigns for pure combinational terms cannot infer latches.
  assign w_slot_free = !r_tx_valid || tx_ready;
  assign w_pl_take   = (r_state == ST_PAYLOAD) && w_slot_free && pl_valid;

  assign pl_ready   = (r_state == ST_PAYLOAD) && w_slot_free;
  assign resp_ready = r_resp_ready;
  assign tx_data    = r_tx_data;
  assign tx_valid   = r_tx_valid;
  assign busy       = r_busy;
  assign err_len    = r_err_len;

  // Frame sequencer: accepts requests, walks the frame and reloads the output slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every register here is plain state; all are reset, none are memories.
      r_state      <= ST_IDLE;
      r_len        <= 8'h00;
      r_cnt        <= 8'h00;
      r_tx_data    <= 8'h00;
      r_tx_valid   <= 1'b0;
      r_busy       <= 1'b0;
      r_err_len    <= 1'b0;
      r_resp_ready <= 1'b0;
`ifdef SERIAL_RESP_CHECKSUM_EN
      r_csum       <= 8'h00;
`endif
    end else begin
      // NOTE: non-blocking defaults first; a later load in the case overrides them.
      r_err_len <= 1'b0;
      if (r_tx_valid && tx_ready) begin
        r_tx_valid <= 1'b0;
      end

      unique case (r_state)
        ST_IDLE: begin
          r_resp_ready <= 1'b1;
          if (resp_valid && r_resp_ready) begin
            if (resp_len > MAX_LEN) begin
              // Oversized request is consumed and reported; nothing is sent.
              r_err_len <= 1'b1;
            end else begin
              r_len        <= resp_len;
              r_cnt        <= 8'h00;
              r_busy       <= 1'b1;
              r_resp_ready <= 1'b0;
              r_tx_data    <= SOF_BYTE;
              r_tx_valid   <= 1'b1;
              r_state      <= ST_SOF2;
`ifdef SERIAL_RESP_CHECKSUM_EN
              r_csum       <= resp_len;
`endif
            end
          end
        end

        ST_SOF2: begin
          if (w_slot_free) begin
            r_tx_data  <= SOF_BYTE;
            r_tx_valid <= 1'b1;
            r_state    <= ST_SPACE;
          end
        end

        ST_SPACE: begin
          if (w_slot_free) begin
            r_tx_data  <= SPACE_BYTE;
            r_tx_valid <= 1'b1;
            r_state    <= ST_LEN;
          end
        end

        ST_LEN: begin
          if (w_slot_free) begin
            r_tx_data  <= r_len;
            r_tx_valid <= 1'b1;
            r_state    <= (r_len == 8'h00) ? ST_AFTER_PL : ST_PAYLOAD;
          end
        end

        ST_PAYLOAD: begin
          // Missing payload leaves the slot empty rather than inserting filler.
          if (w_pl_take) begin
            r_tx_data  <= pl_data;
            r_tx_valid <= 1'b1;
            r_cnt      <= r_cnt + 8'd1;
`ifdef SERIAL_RESP_CHECKSUM_EN
            r_csum     <= r_csum ^ pl_data;
`endif
            if ((r_cnt + 8'd1) == r_len) begin
              r_state <= ST_AFTER_PL;
            end
          end
        end

`ifdef SERIAL_RESP_CHECKSUM_EN
        ST_CSUM: begin
          if (w_slot_free) begin
            r_tx_data  <= r_csum;
            r_tx_valid <= 1'b1;
            r_state    <= ST_EOF1;
          end
        end
`endif

        ST_EOF1: begin
          if (w_slot_free) begin
            r_tx_data  <= EOF_BYTE;
            r_tx_valid <= 1'b1;
            r_state    <= ST_EOF2;
          end
        end

        ST_EOF2: begin
          if (w_slot_free) begin
            r_tx_data  <= EOF_BYTE;
            r_tx_valid <= 1'b1;
            r_state    <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          // Last EOF is in the slot; the frame ends on the edge it is taken.
          if (tx_ready) begin
            r_busy       <= 1'b0;
            r_resp_ready <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
